// File: rtl/rc_step_model.sv
// Fixed-point first-order RC low-pass model: v_out += ALPHA*(v_in - v_out) once per accepted step.
// Three-cycle datapath (difference, multiply, round/saturate/update) with a step_req/step_ack handshake.
module rc_step_model #(
  parameter int WIDTH      = 16,
  parameter int ALPHA_FRAC = 16,
  parameter int ALPHA      = 6237,
  parameter int TIME_W     = 32
) (
  input  logic                     emu_clk,
  input  logic                     emu_rst,
  input  logic                     step_req,
  input  logic                     load,
  input  logic signed [WIDTH-1:0]  v_load,
  input  logic signed [WIDTH-1:0]  v_in,
  output logic                     step_ack,
  output logic                     busy,
  output logic signed [WIDTH-1:0]  v_out,
  output logic [TIME_W-1:0]        t_idx
);

  localparam int DW = WIDTH + 1;
  localparam int PW = WIDTH + ALPHA_FRAC + 2;

  // ALPHA may equal 2^ALPHA_FRAC, so it needs ALPHA_FRAC+1 magnitude bits plus a sign bit.
  localparam logic signed [ALPHA_FRAC+1:0] ALPHA_C = (ALPHA_FRAC+2)'(ALPHA);
  localparam logic signed [PW-1:0] HALF =
    {{(PW-ALPHA_FRAC){1'b0}}, 1'b1, {(ALPHA_FRAC-1){1'b0}}};
  localparam logic signed [PW-1:0] MAXV = PW'((longint'(1) << (WIDTH-1)) - 1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

  typedef enum logic [1:0] {IDLE, MULT, UPDATE} state_t;

  state_t                  state, state_nxt;
  logic signed [DW-1:0]    diff, diff_nxt;
  logic signed [PW-1:0]    prod, prod_nxt;
  logic signed [PW-1:0]    rounded, sum;
  logic signed [WIDTH-1:0] v_sat;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (step_req) state_nxt = MULT;
      MULT:    state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (load) state_nxt = IDLE;
  end

  assign busy = (state != IDLE);

  always_comb begin
    diff_nxt = {v_in[WIDTH-1], v_in} - {v_out[WIDTH-1], v_out};
    prod_nxt = PW'(diff) * PW'(ALPHA_C);
    rounded  = (prod + HALF) >>> ALPHA_FRAC;
    sum      = PW'(v_out) + rounded;
    v_sat    = sum[WIDTH-1:0];
    if (sum > MAXV)      v_sat = MAXV[WIDTH-1:0];
    else if (sum < MINV) v_sat = MINV[WIDTH-1:0];
  end

  // NOTE: sequential state is written only with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: diff/prod are reset too so a step aborted by reset leaves no stale operands behind.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      v_out    <= '0;
      t_idx    <= '0;
      step_ack <= 1'b0;
      diff     <= '0;
      prod     <= '0;
    end else if (load) begin
      v_out    <= v_load;
      t_idx    <= '0;
      step_ack <= 1'b0;
    end else begin
      step_ack <= 1'b0;
      unique case (state)
        IDLE:    if (step_req) diff <= diff_nxt;
        MULT:    prod <= prod_nxt;
        UPDATE: begin
          v_out    <= v_sat;
          t_idx    <= t_idx + TIME_W'(1);
          step_ack <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_step_model.sv
// Self-checking bench for rc_step_model: three instances (nominal ALPHA, ALPHA=1.0 with 4-bit
// t_idx, ALPHA=0) share stimulus and are compared every cycle against a step-level reference.
module tb_rc_step_model;

  logic               emu_clk = 1'b0;
  logic               emu_rst;
  logic               step_req;
  logic               load;
  logic signed [15:0] v_load;
  logic signed [15:0] v_in;
  logic               step_ack [3];
  logic               busy [3];
  logic signed [15:0] v_out [3];
  logic [31:0]        t0;
  logic [3:0]         t1;
  logic [31:0]        t2;

  rc_step_model #(.WIDTH(16), .ALPHA_FRAC(16), .ALPHA(6237), .TIME_W(32)) u_nom (
    .emu_clk(emu_clk), .emu_rst(emu_rst), .step_req(step_req), .load(load),
    .v_load(v_load), .v_in(v_in), .step_ack(step_ack[0]), .busy(busy[0]),
    .v_out(v_out[0]), .t_idx(t0));

  rc_step_model #(.WIDTH(16), .ALPHA_FRAC(16), .ALPHA(65536), .TIME_W(4)) u_full (
    .emu_clk(emu_clk), .emu_rst(emu_rst), .step_req(step_req), .load(load),
    .v_load(v_load), .v_in(v_in), .step_ack(step_ack[1]), .busy(busy[1]),
    .v_out(v_out[1]), .t_idx(t1));

  rc_step_model #(.WIDTH(16), .ALPHA_FRAC(16), .ALPHA(0), .TIME_W(32)) u_zero (
    .emu_clk(emu_clk), .emu_rst(emu_rst), .step_req(step_req), .load(load),
    .v_load(v_load), .v_in(v_in), .step_ack(step_ack[2]), .busy(busy[2]),
    .v_out(v_out[2]), .t_idx(t2));

  always #5 emu_clk = ~emu_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: one step is the recurrence applied with v_in captured at the request edge,
  // delivered two edges later.
  longint alpha_of [3] = '{6237, 65536, 0};
  int     tw_of    [3] = '{32, 4, 32};
  longint mv   [3];
  longint mt   [3];
  longint mvin [3];
  int     mwait[3];   // edges remaining until the pending step completes, 0 = none pending
  bit     mack [3];

  function automatic longint ref_step(longint v, longint vin, longint a);
    longint p, r, s;
    p = (vin - v) * a;
    r = (p + 32768) >>> 16;
    s = v + r;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0; mt[i] = 0; mvin[i] = 0; mwait[i] = 0; mack[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (emu_rst) begin
        mv[i] = 0; mt[i] = 0; mwait[i] = 0; mack[i] = 0;
      end else if (load) begin
        mv[i] = longint'(v_load); mt[i] = 0; mwait[i] = 0; mack[i] = 0;
      end else begin
        mack[i] = 0;
        if (mwait[i] == 0) begin
          if (step_req) begin
            mvin[i]  = longint'(v_in);
            mwait[i] = 2;
          end
        end else if (mwait[i] == 2) begin
          mwait[i] = 1;
        end else begin
          mv[i]    = ref_step(mv[i], mvin[i], alpha_of[i]);
          mt[i]    = (mt[i] + 1) & ((longint'(1) << tw_of[i]) - 1);
          mack[i]  = 1;
          mwait[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    longint tobs;
    for (int i = 0; i < 3; i++) begin
      tobs = (i == 0) ? longint'(t0) : (i == 1) ? longint'(t1) : longint'(t2);
      check($sformatf("v_out%0d", i), longint'(v_out[i]), mv[i]);
      check($sformatf("t_idx%0d", i), tobs, mt[i]);
      check($sformatf("ack%0d", i), longint'(step_ack[i]), longint'(mack[i]));
      check($sformatf("busy%0d", i), longint'(busy[i]), longint'(mwait[i] != 0));
    end
  endtask

  int acks0 = 0;
  int cyc   = 0;
  int last_ack = -1;

  task automatic tick();
    @(posedge emu_clk);
    #1;
    cyc++;
    model_edge();
    compare_all();
    if (step_ack[0]) acks0++;
  endtask

  initial begin
    real ideal, err;
    emu_rst = 1'b1; step_req = 1'b0; load = 1'b0; v_load = '0; v_in = '0;
    model_reset();

    // Reset values visible before the first clock edge.
    #2;
    compare_all();
    tick(); tick();
    emu_rst = 1'b0;
    tick();

    // Step response from 0 toward 4096.
    load = 1'b1; v_load = 16'sd0; tick(); load = 1'b0;
    v_in = 16'sd4096; step_req = 1'b1; tick(); step_req = 1'b0;
    tick();
    check("ack_early", longint'(step_ack[0]), 0);
    tick();
    check("first_ack", longint'(step_ack[0]), 1);
    check("first_v", longint'(v_out[0]), 390);
    check("first_t", longint'(t0), 1);
    step_req = 1'b1;
    for (int k = 2; k <= 50; k++) begin
      tick(); tick(); tick();
      check("resp_ack", longint'(step_ack[0]), 1);
      ideal = 4096.0 * (1.0 - $exp(-0.1 * k));
      err   = real'(v_out[0]) - ideal;
      if (err < 0.0) err = -err;
      check($sformatf("resp_tol_k%0d", k), longint'(err <= 4.0), 1);
    end
    check("resp_t50", longint'(t0), 50);
    step_req = 1'b0;
    tick();

    // Held request: one step per three cycles.
    acks0 = 0; last_ack = -1;
    step_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (step_ack[0]) begin
        if (last_ack >= 0) check("ack_gap", longint'(cyc - last_ack), 3);
        last_ack = cyc;
      end
    end
    step_req = 1'b0;
    check("held_acks", longint'(acks0), 10);
    tick();

    // Request pulsed while in MULT is not queued.
    acks0 = 0;
    step_req = 1'b1; tick(); tick(); step_req = 1'b0;
    tick(); tick(); tick();
    check("pulse_acks", longint'(acks0), 1);
    check("pulse_idle", longint'(busy[0]), 0);

    // Load while a step is in flight aborts it.
    acks0 = 0;
    v_in = 16'sd1000;
    step_req = 1'b1; tick(); step_req = 1'b0;
    load = 1'b1; v_load = -16'sd2048; tick(); load = 1'b0;
    check("abort_v", longint'(v_out[0]), -2048);
    check("abort_t", longint'(t0), 0);
    check("abort_busy", longint'(busy[0]), 0);
    tick(); tick();
    check("abort_acks", longint'(acks0), 0);

    // Full-scale swing with ALPHA=1.0 and frozen output with ALPHA=0.
    load = 1'b1; v_load = 16'sd32767; tick(); load = 1'b0;
    v_in = -16'sd32768;
    step_req = 1'b1; tick(); step_req = 1'b0; tick(); tick();
    check("full_v", longint'(v_out[1]), -32768);
    check("zero_v", longint'(v_out[2]), 32767);
    check("zero_t", longint'(t2), 1);

    // 4-bit step counter wraps after 16 steps.
    load = 1'b1; v_load = 16'sd100; tick(); load = 1'b0;
    step_req = 1'b1;
    for (int s = 0; s < 48; s++) tick();
    step_req = 1'b0;
    check("wrap_t1", longint'(t1), 0);
    check("wrap_t0", longint'(t0), 16);
    check("wrap_zero_v", longint'(v_out[2]), 100);

    // Asynchronous reset while in UPDATE.
    acks0 = 0;
    v_in = 16'sd5000;
    step_req = 1'b1; tick(); step_req = 1'b0; tick();
    #2 emu_rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    tick();
    emu_rst = 1'b0;
    tick();
    check("rst_acks", longint'(acks0), 0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      step_req = ($urandom_range(0, 1) == 1);
      load     = ($urandom_range(0, 19) == 0);
      v_in     = 16'($urandom);
      v_load   = 16'($urandom);
      tick();
    end
    step_req = 1'b0; load = 1'b0;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
